// File: rtl/uart_tx_mmio_pkg.sv
// Shared register map, bit positions and FSM state encoding for the MMIO UART transmitter.
// These values mirror the firmware header constants.
package uart_tx_mmio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_EMPTY_BIT = 2;
  localparam int unsigned STATUS_LEVEL_LSB = 8;
  localparam int unsigned STATUS_OVF_BIT   = 16;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned RV2T_DEFAULT_BAUD_M1 = 867;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Expand the four byte enables into a 32-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty/count; reusable by RX.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_mmio_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             i_sync_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CW-1:0]    w_count_nxt;

  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_sync_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: register file, TX FIFO, baud counter and frame FSM.
// Back-to-back frames pop on the last stop cycle so there is no idle gap between them.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned BAUD_BITS       = 16,
  parameter int unsigned DEFAULT_BAUD_M1 = RV2T_DEFAULT_BAUD_M1
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic [1:0]  reg_addr,
  input  logic [3:0]  reg_write_en,
  input  logic [31:0] reg_write_data,
  input  logic        reg_read_en,
  output logic [31:0] reg_read_data,
  output logic        TXD,
  output logic        tx_active,
  output logic        irq
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [0:0]  LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic [0:0]           r_stop_idx;
  logic [BAUD_BITS-1:0] r_cnt;
  logic [BAUD_BITS-1:0] r_div;
  logic [BAUD_BITS-1:0] r_baud;
  logic                 r_enable;
  logic                 r_irq_en;
  logic                 r_ovf;
  logic                 r_txd;
  logic                 r_tx_active;
  logic                 r_irq;
  logic [31:0]          r_rdata;

  logic [DATA_BITS-1:0] w_fifo_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic                 w_push;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_bit_done;
  logic                 w_clr_ovf;
  logic [31:0]          w_be_mask;
  logic [31:0]          w_baud_wr;
  logic [31:0]          w_rd_word;
  logic                 w_unused;

  assign w_push     = (reg_addr == ADDR_DATA) & reg_write_en[0];
  assign w_accept   = w_push & (~w_full | w_pop);
  assign w_clr_ovf  = (reg_addr == ADDR_STATUS) & reg_write_en[2] & reg_write_data[STATUS_OVF_BIT];
  assign w_bit_done = (r_cnt == '0);
  assign w_pop      = r_enable & ~w_empty &
                      ((r_state == ST_IDLE) |
                       ((r_state == ST_STOP) & w_bit_done & (r_stop_idx == LAST_STOP)));
  assign w_be_mask  = byte_mask(reg_write_en);
  assign w_baud_wr  = (32'(r_baud) & ~w_be_mask) | (reg_write_data & w_be_mask);
  assign w_unused   = ^{reg_write_data, reg_write_en, w_baud_wr};

  uart_tx_mmio_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .i_sync_reset (sync_reset),
    .i_push       (w_push),
    .i_wdata      (reg_write_data[DATA_BITS-1:0]),
    .i_pop        (w_pop),
    .o_rdata      (w_fifo_rdata),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  // Read mux samples pre-write state; the registered copy gives one-cycle latency.
  always_comb begin
    w_rd_word = '0;
    case (reg_addr)
      ADDR_STATUS: begin
        w_rd_word[STATUS_BUSY_BIT]          = r_tx_active;
        w_rd_word[STATUS_FULL_BIT]          = w_full;
        w_rd_word[STATUS_EMPTY_BIT]         = w_empty;
        w_rd_word[STATUS_LEVEL_LSB +: 8]    = 8'(w_count);
        w_rd_word[STATUS_OVF_BIT]           = r_ovf;
      end
      ADDR_BAUD: w_rd_word = 32'(r_baud);
      ADDR_CTRL: begin
        w_rd_word[CTRL_EN_BIT]     = r_enable;
        w_rd_word[CTRL_IRQ_EN_BIT] = r_irq_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_baud   <= BAUD_BITS'(DEFAULT_BAUD_M1);
      r_enable <= 1'b1;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (reg_addr == ADDR_BAUD) r_baud <= w_baud_wr[BAUD_BITS-1:0];
      if ((reg_addr == ADDR_CTRL) && reg_write_en[0]) begin
        r_enable <= reg_write_data[CTRL_EN_BIT];
        r_irq_en <= reg_write_data[CTRL_IRQ_EN_BIT];
      end
      // A dropped push outranks a same-cycle clear.
      if (w_push && !w_accept) r_ovf <= 1'b1;
      else if (w_clr_ovf)      r_ovf <= 1'b0;
      r_irq   <= r_irq_en & w_empty & ~r_tx_active;
      r_rdata <= reg_read_en ? w_rd_word : '0;
    end
  end

  // Frame FSM; the working divisor is latched per frame so BAUD writes apply next frame.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= '0;
      r_cnt       <= '0;
      r_div       <= '0;
      r_txd       <= 1'b1;
      r_tx_active <= 1'b0;
    end else if (w_pop) begin
      r_state     <= ST_START;
      r_shift     <= w_fifo_rdata;
      r_div       <= r_baud;
      r_cnt       <= r_baud;
      r_txd       <= 1'b0;
      r_tx_active <= 1'b1;
    end else begin
      if (!w_bit_done) r_cnt <= r_cnt - BAUD_BITS'(1);
      case (r_state)
        ST_IDLE: ;
        ST_START: begin
          if (w_bit_done) begin
            r_state   <= ST_DATA;
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_cnt     <= r_div;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_cnt <= r_div;
            if (r_bit_idx == LAST_BIT) begin
              r_state    <= ST_STOP;
              r_txd      <= 1'b1;
              r_stop_idx <= '0;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if (r_stop_idx == LAST_STOP) begin
              r_state     <= ST_IDLE;
              r_tx_active <= 1'b0;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
              r_cnt      <= r_div;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reg_read_data = r_rdata;
  assign TXD           = r_txd;
  assign tx_active     = r_tx_active;
  assign irq           = r_irq;

endmodule
